// File: rtl/memory_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
interface memory_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: passes ALU results through, runs load/store handshakes with a
// bounded wait, and reports misaligned/illegal accesses and timeouts as sticky errors.
module memory_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [31:0]          in_ALU,
    input  logic [31:0]          in_dato_registro,
    input  logic [4:0]           in_reg_dest,
    input  logic                 MEM_READ,
    input  logic                 MEM_WRITE,
    input  logic                 REG_WRITE,
    input  logic                 clr_err,
    memory_stage_if.master       mem,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic [31:0]          wb_data,
    output logic [4:0]           wb_reg,
    output logic                 stall,
    output logic                 err_access,
    output logic                 err_timeout
);

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StAccess = 1'b1;
    localparam logic [7:0] LastCnt  = 8'(TIMEOUT - 1);

    logic [0:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  dest_q, dest_d;
    logic        we_q, we_d;
    logic        regw_q, regw_d;
    logic        wb_valid_q, wb_valid_d;
    logic        wb_rw_q, wb_rw_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_reg_q, wb_reg_d;
    logic        err_acc_q, err_acc_d;
    logic        err_to_q, err_to_d;
    logic        acc_evt, to_evt;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        dest_d     = dest_q;
        we_d       = we_q;
        regw_d     = regw_q;
        wb_valid_d = 1'b0;
        wb_rw_d    = wb_rw_q;
        wb_data_d  = wb_data_q;
        wb_reg_d   = wb_reg_q;
        acc_evt    = 1'b0;
        to_evt     = 1'b0;

        if (state_q == StIdle) begin
            if (in_valid) begin
                if (!MEM_READ && !MEM_WRITE) begin
                    wb_valid_d = 1'b1;
                    wb_rw_d    = REG_WRITE;
                    wb_data_d  = in_ALU;
                    wb_reg_d   = in_reg_dest;
                end else if ((in_ALU[1:0] != 2'b00) || (MEM_READ && MEM_WRITE)) begin
                    wb_valid_d = 1'b1;
                    wb_rw_d    = 1'b0;
                    wb_data_d  = in_ALU;
                    wb_reg_d   = in_reg_dest;
                    acc_evt    = 1'b1;
                end else begin
                    addr_d  = in_ALU;
                    wdata_d = in_dato_registro;
                    dest_d  = in_reg_dest;
                    we_d    = MEM_WRITE;
                    regw_d  = REG_WRITE;
                    cnt_d   = 8'd0;
                    state_d = StAccess;
                end
            end
        end else begin
            // An ack on the last allowed cycle wins over the timeout.
            if (mem.mem_ack) begin
                state_d    = StIdle;
                wb_valid_d = 1'b1;
                wb_reg_d   = dest_q;
                wb_rw_d    = we_q ? 1'b0 : regw_q;
                wb_data_d  = we_q ? addr_q : mem.mem_rdata;
            end else if (cnt_q == LastCnt) begin
                state_d    = StIdle;
                wb_valid_d = 1'b1;
                wb_rw_d    = 1'b0;
                wb_data_d  = addr_q;
                wb_reg_d   = dest_q;
                to_evt     = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        err_acc_d = clr_err ? 1'b0 : err_acc_q;
        err_to_d  = clr_err ? 1'b0 : err_to_q;
        if (acc_evt) err_acc_d = 1'b1;
        if (to_evt)  err_to_d  = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            dest_q     <= 5'd0;
            we_q       <= 1'b0;
            regw_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_data_q  <= 32'd0;
            wb_reg_q   <= 5'd0;
            err_acc_q  <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            dest_q     <= dest_d;
            we_q       <= we_d;
            regw_q     <= regw_d;
            wb_valid_q <= wb_valid_d;
            wb_rw_q    <= wb_rw_d;
            wb_data_q  <= wb_data_d;
            wb_reg_q   <= wb_reg_d;
            err_acc_q  <= err_acc_d;
            err_to_q   <= err_to_d;
        end
    end

    // Request decodes straight from state so reset drops it without a clock edge.
    assign mem.mem_req   = (state_q == StAccess);
    assign mem.mem_we    = (state_q == StAccess) && we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign stall        = (state_q != StIdle);
    assign wb_valid     = wb_valid_q;
    assign wb_reg_write = wb_rw_q;
    assign wb_data      = wb_data_q;
    assign wb_reg       = wb_reg_q;
    assign err_access   = err_acc_q;
    assign err_timeout  = err_to_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: expected writebacks queued at issue, checked by a monitor.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] in_ALU;
    logic [31:0] in_dato_registro;
    logic [4:0]  in_reg_dest;
    logic        MEM_READ, MEM_WRITE, REG_WRITE, clr_err;
    logic        wb_valid, wb_reg_write, stall, err_access, err_timeout;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg;

    memory_stage_if mem_bus ();

    memory_stage #(.TIMEOUT(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ALU           (in_ALU),
        .in_dato_registro (in_dato_registro),
        .in_reg_dest      (in_reg_dest),
        .MEM_READ         (MEM_READ),
        .MEM_WRITE        (MEM_WRITE),
        .REG_WRITE        (REG_WRITE),
        .clr_err          (clr_err),
        .mem              (mem_bus),
        .wb_valid         (wb_valid),
        .wb_reg_write     (wb_reg_write),
        .wb_data          (wb_data),
        .wb_reg           (wb_reg),
        .stall            (stall),
        .err_access       (err_access),
        .err_timeout      (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [31:0] data;
        logic [4:0]  rg;
        logic        chk_data;
        logic        chk_reg;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic expect_wb(input logic rw, input logic [31:0] data, input logic [4:0] rg,
                             input logic chk_data, input logic chk_reg);
        exp_t e;
        e.rw = rw; e.data = data; e.rg = rg; e.chk_data = chk_data; e.chk_reg = chk_reg;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_wb: got wb_valid=1, required no writeback");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.rw});
                if (e.chk_data) check("wb_data", wb_data, e.data);
                if (e.chk_reg)  check("wb_reg", {27'd0, wb_reg}, {27'd0, e.rg});
            end
        end
    end

    // Called just after a negedge; the op is accepted on the following posedge.
    task automatic issue(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] dest,
                         input logic rd, input logic wr, input logic rw);
        in_valid = 1'b1; in_ALU = alu; in_dato_registro = wd; in_reg_dest = dest;
        MEM_READ = rd; MEM_WRITE = wr; REG_WRITE = rw;
        @(negedge clk);
        in_valid = 1'b0; MEM_READ = 1'b0; MEM_WRITE = 1'b0; REG_WRITE = 1'b0;
    endtask

    // Entered in the first ACCESS cycle; acks after 'waits' wait cycles.
    task automatic run_access(input logic [31:0] addr, input logic [31:0] wd, input logic we,
                              input int waits, input logic [31:0] rdata, input int exp_cycles);
        int   cyc = 0;
        logic unstable = 1'b0;
        while (mem_bus.mem_req === 1'b1 && cyc < 20) begin
            if (mem_bus.mem_addr !== addr || mem_bus.mem_wdata !== wd || mem_bus.mem_we !== we)
                unstable = 1'b1;
            mem_bus.mem_ack   = (cyc == waits);
            mem_bus.mem_rdata = rdata;
            @(negedge clk);
            cyc++;
        end
        mem_bus.mem_ack = 1'b0;
        check("req_cycles", cyc, exp_cycles);
        check("req_stable", {31'd0, unstable}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of run, required finish within bound");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_ALU = '0; in_dato_registro = '0; in_reg_dest = '0;
        MEM_READ = 1'b0; MEM_WRITE = 1'b0; REG_WRITE = 1'b0; clr_err = 1'b0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
        #3;
        check("rst_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_bus.mem_we}, 32'd0);
        check("rst_mem_addr", mem_bus.mem_addr, 32'd0);
        check("rst_mem_wdata", mem_bus.mem_wdata, 32'd0);
        check("rst_wb", {wb_valid, wb_reg_write, wb_reg, 25'd0}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_flags", {29'd0, stall, err_access, err_timeout}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // ALU passthrough
        expect_wb(1'b1, 32'h0000_0005, 5'd3, 1'b1, 1'b1);
        issue(32'h0000_0005, 32'h0, 5'd3, 1'b0, 1'b0, 1'b1);
        check("alu_stall", {31'd0, stall}, 32'd0);
        check("alu_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);

        // Zero-wait load
        expect_wb(1'b1, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b1);
        issue(32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1);
        check("load_stall", {31'd0, stall}, 32'd1);
        run_access(32'h0000_0100, 32'h0, 1'b0, 0, 32'hDEAD_BEEF, 1);
        check("load_stall_done", {31'd0, stall}, 32'd0);

        // Store with 3 wait states; ack lands on the last allowed cycle
        expect_wb(1'b0, 32'h0000_0200, 5'd9, 1'b1, 1'b0);
        issue(32'h0000_0200, 32'h0000_1234, 5'd9, 1'b0, 1'b1, 1'b1);
        run_access(32'h0000_0200, 32'h0000_1234, 1'b1, 3, 32'h0, 4);
        check("store_errs", {30'd0, err_access, err_timeout}, 32'd0);

        // Timeout
        expect_wb(1'b0, 32'h0, 5'd4, 1'b0, 1'b0);
        issue(32'h0000_0300, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1);
        run_access(32'h0000_0300, 32'h0, 1'b0, 255, 32'h0, 4);
        check("to_err_timeout", {31'd0, err_timeout}, 32'd1);
        check("to_err_access", {31'd0, err_access}, 32'd0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("to_cleared", {31'd0, err_timeout}, 32'd0);

        // Ack while idle is ignored
        mem_bus.mem_ack = 1'b1;
        @(negedge clk); @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        check("idle_ack_stall", {31'd0, stall}, 32'd0);

        // Misaligned load
        expect_wb(1'b0, 32'h0, 5'd2, 1'b0, 1'b0);
        issue(32'h0000_0102, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1);
        check("mis_err_access", {31'd0, err_access}, 32'd1);
        check("mis_mem_req", {30'd0, mem_bus.mem_req, stall}, 32'd0);
        @(negedge clk);
        check("mis_mem_req2", {31'd0, mem_bus.mem_req}, 32'd0);

        // Read+write together, coinciding with clr_err: error must stay set
        expect_wb(1'b0, 32'h0, 5'd1, 1'b0, 1'b0);
        clr_err = 1'b1;
        issue(32'h0000_0040, 32'h0, 5'd1, 1'b1, 1'b1, 1'b1);
        clr_err = 1'b0;
        check("rw_prio_err", {31'd0, err_access}, 32'd1);
        check("rw_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("acc_cleared", {31'd0, err_access}, 32'd0);

        // Reset in the second ACCESS cycle
        issue(32'h0000_0500, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("rst_acc_req_before", {31'd0, mem_bus.mem_req}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_acc_req", {31'd0, mem_bus.mem_req}, 32'd0);
        check("rst_acc_stall", {31'd0, stall}, 32'd0);
        check("rst_acc_wb", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        expect_wb(1'b1, 32'h0000_CAFE, 5'd12, 1'b1, 1'b1);
        issue(32'h0000_CAFE, 32'h0, 5'd12, 1'b0, 1'b0, 1'b1);
        check("post_rst_stall", {31'd0, stall}, 32'd0);

        @(negedge clk); @(negedge clk);
        check("exp_queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
